// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one borrow flip-flop.
// Optional macro SUBTRATOR_OVERFLOW_EN adds a signed-overflow output.
module subtrator_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SUBTRATOR_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("subtrator_serial: WIDTH must be in 2..32");
   end

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg;
   // Only WIDTH-1 partial bits are stored; the last bit goes straight to diff.
   logic [WIDTH-2:0] part_reg;
   logic             br_reg;
   logic [CW-1:0]    cnt_reg;

   logic             ai, bi, di, br_next, last, accept;
   logic [WIDTH-1:0] shifted;

   always_comb begin
      ai      = a_reg[0];
      bi      = b_reg[0];
      di      = ai ^ bi ^ br_reg;
      br_next = (~ai & bi) | (~(ai ^ bi) & br_reg);
      last    = (cnt_reg == LAST);
      accept  = start && (state_reg == OCIOSO || state_reg == FIM);
      shifted = {di, part_reg};
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         OCIOSO:  if (start) state_next = CALCULA;
         CALCULA: if (last)  state_next = FIM;
         FIM:     state_next = start ? CALCULA : OCIOSO;
         default: state_next = OCIOSO;
      endcase
   end

   // busy/done are registered decodes of the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= OCIOSO;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy      <= (state_next == CALCULA);
         done      <= (state_next == FIM);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         part_reg   <= '0;
         br_reg     <= 1'b0;
         cnt_reg    <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
         overflow   <= 1'b0;
`endif
      end else if (accept) begin
         a_reg   <= a;
         b_reg   <= b;
         br_reg  <= 1'b0;
         cnt_reg <= '0;
      end else if (state_reg == CALCULA) begin
         a_reg    <= a_reg >> 1;
         b_reg    <= b_reg >> 1;
         part_reg <= shifted[WIDTH-1:1];
         br_reg   <= br_next;
         cnt_reg  <= cnt_reg + CW'(1);
         if (last) begin
            diff       <= shifted;
            borrow_out <= br_next;
`ifdef SUBTRATOR_OVERFLOW_EN
            // On the last bit ai/bi are the operand MSBs and di is the result MSB.
            overflow   <= (ai != bi) && (di != ai);
`endif
         end
      end
   end

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: directed and random operations against an arithmetic model.
// Build with +define+SUBTRATOR_OVERFLOW_EN to also exercise the overflow output.
module tb_subtrator_serial;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] a, b, diff;
   logic         busy, done, borrow_out;
`ifdef SUBTRATOR_OVERFLOW_EN
   logic         overflow;
`endif

   int checks = 0;
   int failures = 0;

   logic [W-1:0] prev_diff;
   logic         prev_borrow;

   always #5 clk = ~clk;

   subtrator_serial #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SUBTRATOR_OVERFLOW_EN
      ,
      .overflow   (overflow)
`endif
   );

   // Reference: {borrow, diff} from plain unsigned arithmetic.
   function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned ux = x;
      int unsigned uy = y;
      logic [W-1:0] d = W'(ux - uy);
      return {(ux < uy) ? 1'b1 : 1'b0, d};
   endfunction

   // Reference: signed result falls outside the W-bit two's-complement range.
   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
      int sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
      int s  = sx - sy;
      return (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
   endfunction

   // Drives start for exactly one edge, then scrambles the operand inputs.
   task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
      start = 1'b1; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom);
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0)
         $display("FAIL reset_state: busy=%b done=%b diff=%h borrow=%b, want 0 0 00 0", busy, done, diff, borrow_out);
`ifdef SUBTRATOR_OVERFLOW_EN
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_overflow: got %b want 0", overflow);
      end
`endif
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) failures++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
      end
      prev_diff = '0;
      prev_borrow = 1'b0;
   endtask

   task automatic test_arith;
      logic [W-1:0] va[$], vb[$];
      logic [W:0]   e;
      va = '{8'h5A, 8'h00, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h03};
      vb = '{8'h3C, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h02};
      for (int k = 0; k < 20; k++) begin
         va.push_back(W'($urandom));
         vb.push_back(W'($urandom));
      end
      foreach (va[k]) begin
         e = ref_sub(va[k], vb[k]);
         pulse_start(va[k], vb[k]);
         for (int i = 0; i < W; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff || borrow_out !== prev_borrow) begin
               failures++;
               $display("FAIL calc_cycle%0d: busy=%b done=%b diff=%h borrow=%b want 1 0 %h %b",
                        i, busy, done, diff, borrow_out, prev_diff, prev_borrow);
            end
            @(negedge clk);
         end
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || diff !== e[W-1:0] || borrow_out !== e[W]) begin
            failures++;
            $display("FAIL result: a=%h b=%h done=%b busy=%b diff=%h borrow=%b want 1 0 %h %b",
                     va[k], vb[k], done, busy, diff, borrow_out, e[W-1:0], e[W]);
         end
`ifdef SUBTRATOR_OVERFLOW_EN
         checks++;
         if (overflow !== ref_ovf(va[k], vb[k])) begin
            failures++;
            $display("FAIL overflow_arith: a=%h b=%h got %b want %b", va[k], vb[k], overflow, ref_ovf(va[k], vb[k]));
         end
`endif
         $display("op a=%h b=%h diff=%h borrow=%b (expected %h %b)", va[k], vb[k], diff, borrow_out, e[W-1:0], e[W]);
         prev_diff = e[W-1:0];
         prev_borrow = e[W];
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || diff !== prev_diff || borrow_out !== prev_borrow) begin
            failures++;
            $display("FAIL after_done: done=%b busy=%b diff=%h borrow=%b want 0 0 %h %b",
                     done, busy, diff, borrow_out, prev_diff, prev_borrow);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] a1 = W'($urandom);
      logic [W-1:0] b1 = W'($urandom);
      logic [W:0]   e1 = ref_sub(a1, b1);
      logic [W:0]   e2 = ref_sub(8'h10, 8'h20);
      pulse_start(a1, b1);
      for (int i = 0; i < W; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_busy%0d: got %b want 1", i, busy);
         end
         if (i == W - 1) begin
            start = 1'b1; a = 8'h10; b = 8'h20;
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || diff !== e1[W-1:0] || borrow_out !== e1[W]) begin
         failures++;
         $display("FAIL b2b_first_result: done=%b diff=%h borrow=%b want 1 %h %b", done, diff, borrow_out, e1[W-1:0], e1[W]);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || diff !== e1[W-1:0] || borrow_out !== e1[W]) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b done=%b diff=%h borrow=%b want 1 0 %h %b",
                  busy, done, diff, borrow_out, e1[W-1:0], e1[W]);
      end
      for (int i = 1; i < W; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b1 || diff !== e1[W-1:0]) begin
            failures++;
            $display("FAIL b2b_second_busy%0d: busy=%b diff=%h want 1 %h", i, busy, diff, e1[W-1:0]);
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || diff !== e2[W-1:0] || borrow_out !== e2[W]) begin
         failures++;
         $display("FAIL b2b_second_result: done=%b diff=%h borrow=%b want 1 %h %b", done, diff, borrow_out, e2[W-1:0], e2[W]);
      end
      $display("op b2b a=%h b=%h then a=10 b=20 diff=%h borrow=%b", a1, b1, diff, borrow_out);
      prev_diff = e2[W-1:0];
      prev_borrow = e2[W];
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_ignore_start;
      logic [W-1:0] av = W'($urandom);
      logic [W-1:0] bv = W'($urandom);
      logic [W:0]   e = ref_sub(av, bv);
      int           dcnt = 0;
      pulse_start(av, bv);
      for (int j = 0; j < W + 4; j++) begin
         if (j == 2) begin
            start = 1'b1; a = ~av; b = ~bv + 8'h5;
         end else if (j == 3) begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            dcnt++;
            checks++;
            if (diff !== e[W-1:0] || borrow_out !== e[W]) begin
               failures++;
               $display("FAIL ignore_result: diff=%h borrow=%b want %h %b", diff, borrow_out, e[W-1:0], e[W]);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (dcnt != 1) begin
         failures++;
         $display("FAIL ignore_done_count: got %0d want 1", dcnt);
      end
      $display("op ignore a=%h b=%h diff=%h done_pulses=%0d", av, bv, diff, dcnt);
      prev_diff = e[W-1:0];
      prev_borrow = e[W];
   endtask

   task automatic test_reset_mid;
      int j;
      pulse_start(W'($urandom), W'($urandom));
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0", busy, done, diff, borrow_out);
      end
      @(negedge clk);
      rst = 1'b0;
      for (j = 0; j < W + 2; j++) begin
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || diff !== '0) begin
            failures++;
            $display("FAIL reset_no_done%0d: done=%b busy=%b diff=%h want 0 0 00", j, done, busy, diff);
         end
         @(negedge clk);
      end
      pulse_start(8'h03, 8'h02);
      for (j = 0; j < W + 4 && done !== 1'b1; j++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || diff !== 8'h01 || borrow_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_fresh_op: done=%b diff=%h borrow=%b want 1 01 0", done, diff, borrow_out);
      end
      $display("op after reset a=03 b=02 diff=%h borrow=%b", diff, borrow_out);
      prev_diff = 8'h01;
      prev_borrow = 1'b0;
      @(negedge clk);
   endtask

`ifdef SUBTRATOR_OVERFLOW_EN
   task automatic test_overflow;
      logic [W-1:0] va[$], vb[$];
      logic [W:0]   e;
      va = '{8'h80, 8'h7F, 8'h7F, 8'h80};
      vb = '{8'h01, 8'h01, 8'hFF, 8'h7F};
      for (int k = 0; k < 8; k++) begin
         va.push_back(W'($urandom));
         vb.push_back(W'($urandom));
      end
      foreach (va[k]) begin
         e = ref_sub(va[k], vb[k]);
         pulse_start(va[k], vb[k]);
         for (int j = 0; j < W + 4 && done !== 1'b1; j++) @(negedge clk);
         checks++;
         if (done !== 1'b1 || diff !== e[W-1:0] || borrow_out !== e[W] || overflow !== ref_ovf(va[k], vb[k])) begin
            failures++;
            $display("FAIL overflow: a=%h b=%h done=%b diff=%h borrow=%b ovf=%b want 1 %h %b %b",
                     va[k], vb[k], done, diff, borrow_out, overflow, e[W-1:0], e[W], ref_ovf(va[k], vb[k]));
         end
         $display("op ovf a=%h b=%h diff=%h borrow=%b overflow=%b", va[k], vb[k], diff, borrow_out, overflow);
         prev_diff = e[W-1:0];
         prev_borrow = e[W];
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      test_reset;
      test_arith;
      test_back_to_back;
      test_ignore_start;
      test_reset_mid;
`ifdef SUBTRATOR_OVERFLOW_EN
      test_overflow;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
